// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: incrementing-byte payload, configurable length, gap and count.
// Optional define PKTGEN_SEQNUM_EN puts the run-relative packet number in tdata[31:0] of beat 0.
module axis_pkt_gen (
  input  logic        m_axis_aclk,
  input  logic        m_axis_areset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] pkt_len,
  input  logic [15:0] gap_cycles,
  input  logic [31:0] pkt_count,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic [31:0] sent_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  tail_q, tail_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] cnt_q, cnt_d;
  logic [12:0] last_beat_q, last_beat_d;
  logic [12:0] beat_q, beat_d;
  logic [15:0] gap_ctr_q, gap_ctr_d;
  logic [31:0] pkt_idx_q, pkt_idx_d;
  logic        stop_pend_q, stop_pend_d;
  logic [31:0] sent_q, sent_d;

  logic        final_beat;
  logic        run_done;
  logic [15:0] len_m1;

  assign final_beat = (beat_q == last_beat_q);
  assign run_done   = (cnt_q != '0) && ((pkt_idx_q + 32'd1) == cnt_q);
  assign len_m1     = pkt_len - 16'd1;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q     <= IDLE;
      tail_q      <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
      last_beat_q <= '0;
      beat_q      <= '0;
      gap_ctr_q   <= '0;
      pkt_idx_q   <= '0;
      stop_pend_q <= 1'b0;
      sent_q      <= '0;
    end else begin
      state_q     <= state_d;
      tail_q      <= tail_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      last_beat_q <= last_beat_d;
      beat_q      <= beat_d;
      gap_ctr_q   <= gap_ctr_d;
      pkt_idx_q   <= pkt_idx_d;
      stop_pend_q <= stop_pend_d;
      sent_q      <= sent_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tail_d      = tail_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;
    last_beat_d = last_beat_q;
    beat_d      = beat_q;
    gap_ctr_d   = gap_ctr_q;
    pkt_idx_d   = pkt_idx_q;
    stop_pend_d = stop_pend_q;
    sent_d      = sent_q;

    unique case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && (pkt_len != '0)) begin
          tail_d      = pkt_len[2:0];
          gap_d       = gap_cycles;
          cnt_d       = pkt_count;
          // ceil(len/8)-1 == floor((len-1)/8) for len >= 1
          last_beat_d = len_m1[15:3];
          beat_d      = '0;
          pkt_idx_d   = '0;
          // a stop arriving with the start only takes effect after the first packet
          stop_pend_d = stop;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (m_axis_tready) begin
          if (final_beat) begin
            sent_d    = sent_q + 32'd1;
            pkt_idx_d = pkt_idx_q + 32'd1;
            beat_d    = '0;
            if (run_done || stop_pend_q || stop) begin
              state_d     = IDLE;
              stop_pend_d = 1'b0;
            end else if (gap_q != '0) begin
              state_d   = GAP;
              gap_ctr_d = gap_q - 16'd1;
            end
          end else begin
            beat_d = beat_q + 13'd1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end else if (gap_ctr_q == '0) begin
          state_d = SEND;
        end else begin
          gap_ctr_d = gap_ctr_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [63:0] data;
  logic [7:0]  keep;

  always_comb begin
    data = '0;
    keep = '0;
    if (state_q == SEND) begin
      // byte k of beat b is (8*b+k) mod 256, i.e. {b[4:0], k[2:0]}
      for (int unsigned k = 0; k < 8; k++) begin
        data[8*k +: 8] = {beat_q[4:0], 3'(k)};
      end
`ifdef PKTGEN_SEQNUM_EN
      if (beat_q == '0) data[31:0] = pkt_idx_q;
`endif
      if (final_beat && (tail_q != '0)) keep = ~(8'hFF << tail_q);
      else                              keep = 8'hFF;
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = data;
  assign m_axis_tkeep  = keep;
  assign m_axis_tlast  = (state_q == SEND) && final_beat;
  assign m_axis_tuser  = 1'b0;
  assign busy          = (state_q != IDLE);
  assign sent_count    = sent_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: cycle model of the packet stream plus directed scenarios.
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, tready;
  logic [15:0] pkt_len, gap_cycles;
  logic [31:0] pkt_count;
  logic        tvalid, tlast, tuser, busy;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [31:0] sent_count;

  always #5 clk = ~clk;

  axis_pkt_gen dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .start         (start),
    .stop          (stop),
    .pkt_len       (pkt_len),
    .gap_cycles    (gap_cycles),
    .pkt_count     (pkt_count),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .busy          (busy),
    .sent_count    (sent_count)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // behavioural model of the run
  bit        m_busy = 0;
  int        m_gapleft = 0;
  int        m_beat = 0;
  int        m_len = 0;
  int        m_gap = 0;
  bit [31:0] m_cnt = 0, m_idx = 0, m_sent = 0;
  bit        m_stop = 0;
  bit        m_inrst = 1;

  int        n_xfer = 0, n_last = 0, n_lowbusy = 0;
  bit [63:0] xd[int];
  bit [7:0]  xk[int];
  bit [63:0] b0d[int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_data(input int beat);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'((8*beat + k) % 256);
`ifdef PKTGEN_SEQNUM_EN
    if (beat == 0) d[31:0] = m_idx;
`endif
    return d;
  endfunction

  function automatic logic [7:0] exp_keep(input bit last);
    if (!last || (m_len % 8) == 0) return 8'hFF;
    return 8'((1 << (m_len % 8)) - 1);
  endfunction

  // one clock: compare outputs, advance model with the inputs about to be sampled
  task automatic tick();
    bit ev, el;
    int nb;
    @(negedge clk);
    nb = (m_len + 7) / 8;
    ev = m_busy && (m_gapleft == 0);
    el = ev && (m_beat == nb - 1);
    chk("tvalid", 64'(tvalid), 64'(ev));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("sent_count", 64'(sent_count), 64'(m_sent));
    chk("tuser", 64'(tuser), 64'(0));
    if (ev) begin
      chk("tdata", tdata, exp_data(m_beat));
      chk("tkeep", 64'(tkeep), 64'(exp_keep(el)));
      chk("tlast", 64'(tlast), 64'(el));
    end
    if (m_inrst) begin
      chk("rst_tdata", tdata, 64'(0));
      chk("rst_tkeep", 64'(tkeep), 64'(0));
      chk("rst_tlast", 64'(tlast), 64'(0));
    end
    if (tvalid && tready) begin
      xd[n_xfer] = tdata;
      xk[n_xfer] = tkeep;
      if (ev && m_beat == 0) b0d[n_last] = tdata;
      n_xfer++;
      if (tlast) n_last++;
    end
    if (busy && !tvalid) n_lowbusy++;

    m_inrst = rst;
    if (rst) begin
      m_busy = 0; m_gapleft = 0; m_beat = 0; m_stop = 0; m_sent = 0; m_idx = 0;
    end else if (!m_busy) begin
      m_stop = 0;
      if (start && pkt_len != 0) begin
        m_len = pkt_len; m_gap = gap_cycles; m_cnt = pkt_count;
        m_busy = 1; m_beat = 0; m_idx = 0; m_gapleft = 0; m_stop = stop;
      end
    end else if (m_gapleft > 0) begin
      if (stop) begin m_busy = 0; m_stop = 0; m_gapleft = 0; end
      else m_gapleft--;
    end else begin
      if (stop) m_stop = 1;
      if (tready) begin
        if (m_beat == nb - 1) begin
          m_sent++;
          m_idx++;
          m_beat = 0;
          if ((m_cnt != 0 && m_idx == m_cnt) || m_stop) begin
            m_busy = 0; m_stop = 0;
          end else begin
            m_gapleft = m_gap;
          end
        end else begin
          m_beat++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int len, input int gap, input int cnt);
    pkt_len = 16'(len); gap_cycles = 16'(gap); pkt_count = 32'(cnt);
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_idle(input int limit, input bit toggle);
    int i = 0;
    while (busy && i < limit) begin
      if (toggle) tready = ~tready;
      tick();
      i++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
    tready = 1;
  endtask

  int bx, bl, bw, lim;

  initial begin
    rst = 1; start = 0; stop = 0; tready = 1;
    pkt_len = 0; gap_cycles = 0; pkt_count = 0;
    repeat (3) tick();
    chk("reset_tvalid", 64'(tvalid), 64'(0));
    chk("reset_sent", 64'(sent_count), 64'(0));
    rst = 0; tick();

    // 64 bytes back-to-back, two packets
    bx = n_xfer; bl = n_last; bw = n_lowbusy;
    run(64, 0, 2); wait_idle(200, 0);
    chk("sc1_xfers", 64'(n_xfer - bx), 64'(16));
    chk("sc1_lasts", 64'(n_last - bl), 64'(2));
    chk("sc1_idle_between", 64'(n_lowbusy - bw), 64'(0));
    chk("sc1_tlast_beat8", 64'(xk[bx+7]), 64'(8'hFF));
    chk("sc1_sent", 64'(sent_count), 64'(2));

    // 61-byte packet, partial last beat
    bx = n_xfer;
    run(61, 0, 1); wait_idle(100, 0);
    chk("sc2_xfers", 64'(n_xfer - bx), 64'(8));
    chk("sc2_keep", 64'(xk[bx+7]), 64'(8'h1F));
    chk("sc2_data7", xd[bx+7], 64'h3F3E3D3C3B3A3938);
    chk("sc2_sent", 64'(sent_count), 64'(3));

    // 17-byte packet with toggling ready
    bx = n_xfer;
    tready = 0;
    run(17, 0, 1); wait_idle(100, 1);
    chk("sc3_xfers", 64'(n_xfer - bx), 64'(3));
    chk("sc3_keep", 64'(xk[bx+2]), 64'(8'h01));
    chk("sc3_data2", xd[bx+2], 64'h1716151413121110);

    // unlimited 8-byte packets with gap 5, stop during packet 3
    bl = n_last; bw = n_lowbusy;
    run(8, 5, 0);
    lim = 0;
    while (!(tvalid && (n_last - bl) == 2) && lim < 100) begin tick(); lim++; end
    chk("sc4_reach_pkt3", 64'(tvalid), 64'(1));
    stop = 1; tick(); stop = 0;
    wait_idle(100, 0);
    chk("sc4_pkts", 64'(n_last - bl), 64'(3));
    chk("sc4_gap_cycles", 64'(n_lowbusy - bw), 64'(10));
    chk("sc4_sent", 64'(sent_count), 64'(7));

    // zero-length start is ignored
    run(0, 0, 1);
    chk("len0_ignored", 64'(busy), 64'(0));

    // start and stop together: first packet completes, then idle
    bx = n_xfer; bl = n_last;
    pkt_len = 16; gap_cycles = 2; pkt_count = 0;
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    wait_idle(100, 0);
    chk("same_cycle_xfers", 64'(n_xfer - bx), 64'(2));
    chk("same_cycle_pkts", 64'(n_last - bl), 64'(1));

    // reset during beat 4 of a 64-byte packet
    bx = n_xfer;
    run(64, 0, 0);
    lim = 0;
    while ((n_xfer - bx) < 3 && lim < 100) begin tick(); lim++; end
    rst = 1; start = 1; tick(); start = 0;
    chk("rst_mid_tvalid", 64'(tvalid), 64'(0));
    rst = 0; tick();
    chk("rst_mid_sent", 64'(sent_count), 64'(0));
    chk("rst_start_ignored", 64'(busy), 64'(0));
    bx = n_xfer;
    run(16, 0, 1); wait_idle(100, 0);
    chk("post_rst_xfers", 64'(n_xfer - bx), 64'(2));
    chk("post_rst_sent", 64'(sent_count), 64'(1));

`ifdef PKTGEN_SEQNUM_EN
    bl = n_last;
    run(20, 1, 3); wait_idle(200, 0);
    for (int p = 0; p < 3; p++) begin
      chk("seq_low", 64'(b0d[bl+p][31:0]), 64'(p));
      chk("seq_high", 64'(b0d[bl+p][63:32]), 64'h07060504);
    end
`endif

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tready = ($urandom % 4) != 0;
      pkt_len = 16'($urandom_range(0, 40));
      gap_cycles = 16'($urandom_range(0, 3));
      pkt_count = 32'($urandom_range(0, 3));
      start = busy ? (($urandom % 16) == 0) : (($urandom % 6) == 0);
      stop = ($urandom % 40) == 0;
      rst = ($urandom % 1000) == 0;
      tick();
    end
    start = 0; rst = 0; tready = 1;
    stop = 1; tick(); stop = 0;
    wait_idle(500, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
